// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction-decode stage with two-entry skid buffer
module decode_stage #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 32,
  parameter logic [2**OPC_W-1:0] VALID_OPC_MASK = '1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [INSTR_W-1:0]                 in_instr,
  input  logic [PC_W-1:0]                    in_pc,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OPC_W-1:0]                   out_opcode,
  output logic [REG_W-1:0]                   out_reg_d,
  output logic [REG_W-1:0]                   out_reg_b,
  output logic [REG_W-1:0]                   out_reg_a,
  output logic [INSTR_W-OPC_W-3*REG_W-1:0]   out_offset,
  output logic [DATA_W-1:0]                  out_imm,
  output logic                               out_illegal,
  output logic [PC_W-1:0]                    out_pc,
  output logic [CNT_W-1:0]                   decoded_count
);
  localparam int OFF_W = INSTR_W - OPC_W - 3*REG_W;

  logic [INSTR_W-1:0] main_instr, skid_instr;
  logic [PC_W-1:0]    main_pc, skid_pc;
  logic               main_valid, skid_valid;
  logic               accept, handshake;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign handshake = main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid    <= 1'b0;
      skid_valid    <= 1'b0;
      main_instr    <= '0;
      main_pc       <= '0;
      skid_instr    <= '0;
      skid_pc       <= '0;
      decoded_count <= '0;
    end else begin
      if (handshake)
        decoded_count <= decoded_count + CNT_W'(1);
      if (flush) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!main_valid || out_ready) begin
        if (skid_valid) begin
          main_instr <= skid_instr;
          main_pc    <= skid_pc;
          main_valid <= 1'b1;
          skid_valid <= accept;
          if (accept) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
          end
        end else if (accept) begin
          main_instr <= in_instr;
          main_pc    <= in_pc;
          main_valid <= 1'b1;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
        skid_valid <= 1'b1;
      end
    end
  end

  assign out_opcode  = main_instr[OPC_W-1:0];
  assign out_reg_d   = main_instr[OPC_W +: REG_W];
  assign out_reg_b   = main_instr[OPC_W+REG_W +: REG_W];
  assign out_reg_a   = main_instr[OPC_W+2*REG_W +: REG_W];
  assign out_offset  = main_instr[INSTR_W-1 -: OFF_W];
  assign out_imm     = DATA_W'($signed(out_offset));
  assign out_illegal = !VALID_OPC_MASK[out_opcode];
  assign out_pc      = main_pc;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_illegal;
  logic [3:0]  out_opcode;
  logic [4:0]  out_reg_d, out_reg_b, out_reg_a;
  logic [12:0] out_offset;
  logic [31:0] out_imm, out_pc, decoded_count;

  logic        in_ready2, out_valid2, out_illegal2;
  logic [3:0]  out_opcode2;
  logic [4:0]  out_reg_d2, out_reg_b2, out_reg_a2;
  logic [12:0] out_offset2;
  logic [31:0] out_imm2, out_pc2;
  logic [3:0]  decoded_count2;

  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic [63:0] q[$];
  logic [31:0] hs_count = '0;
  logic [63:0] item;
  logic [31:0] ei, ep;
  logic        ready_m;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_reg_d(out_reg_d), .out_reg_b(out_reg_b),
    .out_reg_a(out_reg_a), .out_offset(out_offset), .out_imm(out_imm),
    .out_illegal(out_illegal), .out_pc(out_pc), .decoded_count(decoded_count)
  );

  decode_stage #(.VALID_OPC_MASK(16'h00FF), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid2), .out_ready(out_ready),
    .out_opcode(out_opcode2), .out_reg_d(out_reg_d2), .out_reg_b(out_reg_b2),
    .out_reg_a(out_reg_a2), .out_offset(out_offset2), .out_imm(out_imm2),
    .out_illegal(out_illegal2), .out_pc(out_pc2), .decoded_count(decoded_count2)
  );

  // Scoreboard: q mirrors the instructions currently held in the stage.
  always @(negedge clk) begin
    if (mon_en) begin
      ready_m = (q.size() < 2);
      total++;
      if (out_valid !== (q.size() != 0)) begin
        bad++; $display("FAIL out_valid: got %b want %b", out_valid, q.size() != 0);
      end
      total++;
      if (in_ready !== ready_m || in_ready2 !== ready_m) begin
        bad++; $display("FAIL in_ready: got %b/%b want %b", in_ready, in_ready2, ready_m);
      end
      total++;
      if (decoded_count !== hs_count || decoded_count2 !== hs_count[3:0]) begin
        bad++; $display("FAIL count: got %0d/%0d want %0d", decoded_count, decoded_count2, hs_count);
      end
      if (reset) begin
        q.delete();
        hs_count = '0;
      end else begin
        if (out_valid && out_ready) begin
          hs_count = hs_count + 1;
          total++;
          if (q.size() == 0) begin
            bad++; $display("FAIL spurious_output: got pc %h want none", out_pc);
          end else begin
            item = q.pop_front();
            ei = item[63:32];
            ep = item[31:0];
            if (out_opcode !== ei[3:0] || out_reg_d !== ei[8:4] || out_reg_b !== ei[13:9] ||
                out_reg_a !== ei[18:14] || out_offset !== ei[31:19] ||
                out_imm !== {{19{ei[31]}}, ei[31:19]} || out_pc !== ep || out_illegal !== 1'b0 ||
                out_illegal2 !== ei[3] || out_pc2 !== ep) begin
              bad++;
              $display("FAIL decode: got opc=%h d=%h b=%h a=%h off=%h imm=%h pc=%h ill=%b/%b want instr=%h pc=%h",
                       out_opcode, out_reg_d, out_reg_b, out_reg_a, out_offset, out_imm, out_pc,
                       out_illegal, out_illegal2, ei, ep);
            end
          end
        end
        if (flush) q.delete();
        else if (in_valid && ready_m) q.push_back({in_instr, in_pc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    tick();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain_timeout: got %0d held want 0", q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 0 || out_imm !== 0 ||
        out_opcode !== 0 || out_offset !== 0 || decoded_count !== 0 || out_illegal !== 0) begin
      bad++; $display("FAIL reset_state: got v=%b r=%b pc=%h imm=%h cnt=%0d want 0/1/0/0/0",
                      out_valid, in_ready, out_pc, out_imm, decoded_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_instr = 32'h8004_2A53; in_pc = 32'h100; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_opcode !== 4'd3 || out_reg_d !== 5'd5 || out_reg_b !== 5'h15 ||
        out_reg_a !== 5'h10 || out_offset !== 13'h1000 || out_imm !== 32'hFFFF_F000 ||
        out_pc !== 32'h100) begin
      bad++; $display("FAIL single_decode: got v=%b opc=%h d=%h b=%h a=%h off=%h imm=%h pc=%h want 1/3/5/15/10/1000/fffff000/100",
                      out_valid, out_opcode, out_reg_d, out_reg_b, out_reg_a, out_offset, out_imm, out_pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (decoded_count !== 32'd1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL single_count: got cnt=%0d v=%b want 1/0", decoded_count, out_valid);
    end
  endtask

  task automatic stream(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_instr = $urandom; in_pc = 32'h1000 + 4*i;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] base;
    base = decoded_count;
    stream(16);
    tick();
    total++;
    if (decoded_count !== base + 32'd16 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stream_count: got %0d v=%b want %0d/0", decoded_count, out_valid, base + 16);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hAAAA_0011; in_pc = 32'h200;
    tick();
    in_instr = 32'hBBBB_0022; in_pc = 32'h204;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready1: got %b want 1", in_ready); end
    tick();
    in_instr = 32'hCCCC_0033; in_pc = 32'h208;
    total++;
    if (in_ready !== 1'b0 || q.size() != 2) begin
      bad++; $display("FAIL stall_ready2: got r=%b held=%0d want 0/2", in_ready, q.size());
    end
    tick();
    total++;
    if (in_ready !== 1'b0 || out_pc !== 32'h200) begin
      bad++; $display("FAIL stall_hold: got r=%b pc=%h want 0/200", in_ready, out_pc);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_pc !== 32'h204) begin
      bad++; $display("FAIL stall_release: got r=%b pc=%h want 1/204", in_ready, out_pc);
    end
    tick();
    drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000_1239; in_pc = 32'h300;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_illegal2 !== 1'b1 || out_illegal !== 1'b0) begin
      bad++; $display("FAIL illegal_opc9: got %b/%b want 1/0", out_illegal2, out_illegal);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0000_1237; in_pc = 32'h304;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_illegal2 !== 1'b0 || out_illegal !== 1'b0) begin
      bad++; $display("FAIL illegal_opc7: got %b/%b want 0/0", out_illegal2, out_illegal);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h1111_1111; in_pc = 32'h400;
    tick();
    in_instr = 32'h2222_2222; in_pc = 32'h404;
    tick();
    flush = 1'b1; in_instr = 32'h3333_3333; in_pc = 32'h408;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush: got v=%b r=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_wrap_and_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stream(17);
    drain();
    total++;
    if (decoded_count2 !== 4'd1 || decoded_count !== 32'd17) begin
      bad++; $display("FAIL wrap: got %0d/%0d want 1/17", decoded_count2, decoded_count);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; in_pc = 32'h500;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 0 || out_imm !== 0 ||
        out_reg_a !== 0 || decoded_count !== 0 || decoded_count2 !== 0) begin
      bad++; $display("FAIL mid_reset: got v=%b r=%b pc=%h imm=%h cnt=%0d want 0/1/0/0/0",
                      out_valid, in_ready, out_pc, out_imm, decoded_count);
    end
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_stall();
    test_illegal();
    test_flush();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
